miriscv_lsu: RTL
================

// Module: miriscv_lsu
// PURPOSE
//   Load/store unit directly downstream of the ALU. Takes the ALU result as the effective address
//   plus rs2 data and a size code from the decoder, runs one data-memory transaction over a
//   req/ack handshake, and stalls the core until it completes.
//   Returns sign- or zero-extended load data to the register-file write-back mux.
// PARAMETERS
//   ADDR_W   32  address width (ALU result width)
//   DATA_W   32  data width; fixed to 32 (4 byte lanes)
// PORTS
//   clk        in   1   core clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   lsu_req    in   1   decoder: current instruction is a load/store
//   lsu_we     in   1   1 = store, 0 = load
//   lsu_size   in   3   funct3: 0=B 1=H 2=W 4=BU 5=HU; 3/6/7 illegal
//   lsu_addr   in   32  effective address from ALU result
//   lsu_wdata  in   32  store data (rs2)
//   lsu_rdata  out  32  extended load data, valid while lsu_done=1
//   lsu_done   out  1   one-cycle pulse: transaction finished, core may advance
//   lsu_stall  out  1   core must hold PC and suppress write-back
//   lsu_fault  out  1   misaligned or illegal size; no memory access issued
//   mem_req    out  1   memory request, registered
//   mem_we     out  1   memory write enable, registered
//   mem_be     out  4   byte enables, registered
//   mem_addr   out  32  word-aligned address {lsu_addr[31:2],2'b00}, registered
//   mem_wdata  out  32  lane-replicated store data, registered
//   mem_rdata  in   32  memory read word, sampled when mem_ack=1
//   mem_ack    in   1   memory completes the request this cycle
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, lsu_done=0; mem_be=0;
//   mem_addr, mem_wdata, lsu_rdata=0. Takes effect immediately, also mid-transaction;
//   mem_req drops at once and an outstanding ack is ignored.
// - FSM:
//   - IDLE: lsu_req & !fault -> BUSY; register mem_* with mem_req=1.
//   - BUSY: hold all mem_* stable until mem_ack. On ack: latch extended data into lsu_rdata
//     (loads only), mem_req=0, -> DONE.
//   - DONE: lsu_done=1 for exactly one cycle, -> IDLE. lsu_req seen in DONE belongs to the
//     finished instruction and is ignored.
// - Stall and fault:
//   - lsu_stall = (IDLE & lsu_req & !fault) | BUSY; combinational; 0 in DONE.
//   - fault: size illegal, or H/HU with addr[0]=1, or W with addr[1:0]!=0.
//   - lsu_fault = IDLE & lsu_req & fault; no stall, no mem_req, state stays IDLE.
// - Latency: req at cycle 0 -> mem_req from cycle 1 -> ack at cycle k>=1 -> lsu_done
//   and lsu_stall=0 at cycle k+1. Minimum is 3 cycles. No upper bound, no timeout.
// - Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<addr[1:0]; W 4'b1111.
//   mem_be is driven for loads too.
// - Store data: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
// - Load extract: byte lane addr[1:0] (or half lane addr[1]) of mem_rdata.
//   B/H sign-extend, BU/HU zero-extend, W passthrough.
//   lsu_rdata holds its last value outside DONE; it is not updated by stores.
// - Boundaries:
//   - mem_ack in IDLE/DONE is ignored.
//   - An ack in the same cycle mem_req first rises is valid.
//   - Addr 0xFFFF_FFFC word access is legal; no wrap handling needed.
// STRUCTURE
// - defines.v gains:
//   - `LDST_B/H/W/BU/HU size codes;
//   - `LSU_IDLE/BUSY/DONE 2-bit state encodings.
// - One combinational sub-module, lsu_load_align:
//   (mem_rdata, offset[1:0], size) -> extended 32-bit result.
//   It is reused by the bench as the reference model.
// TESTING
// - Reset values:
//   - assert rst_n=0 async mid-cycle while BUSY -> mem_req=0, state IDLE at once;
//   - a later ack produces no lsu_done.
// - SB addr=0x0000_1003 wdata=0x1234_56AB, ack next cycle
//   -> mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xABAB_ABAB;
//   -> stall for 2 cycles, then lsu_done=1.
// - LB/LBU addr=0x2001 with mem_rdata=0x0000_8000:
//   -> LB: lsu_rdata=0xFFFF_FF80;
//   -> LBU: lsu_rdata=0x0000_0080.
// - LH addr=0x2002, mem_rdata=0x8001_0000 -> lsu_rdata=0xFFFF_8001, mem_be=4'b1100.
//   Same with LHU -> 0x0000_8001.
// - Misaligned and illegal cases:
//   - LW addr=0x2002 -> lsu_fault=1, lsu_stall=0, mem_req never rises;
//   - SH addr=0x2001 -> same;
//   - lsu_size=3 -> same.
// - Ack held off 5 cycles:
//   -> mem_* stable, lsu_stall=1 throughout;
//   -> lsu_done exactly one cycle after ack;
//   -> lsu_req held high in DONE does not start a second request.

Source files
------------

// File: rtl/miriscv_lsu_pkg.sv
// Shared definitions for the MIRISCV load/store unit: funct3 size codes, FSM states,
// and the per-access decode helpers used by the top level.
package miriscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    // Illegal size codes and accesses not aligned to their natural size both fault.
    function automatic logic lsu_is_fault(input logic [2:0] size, input logic [1:0] off);
        logic f;
        case (size)
            LDST_B, LDST_BU: f = 1'b0;
            LDST_H, LDST_HU: f = off[0];
            LDST_W:          f = (off != 2'b00);
            default:         f = 1'b1;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] lsu_byte_en(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            LDST_B, LDST_BU: be = 4'b0001 << off;
            LDST_H, LDST_HU: be = 4'b0011 << off;
            LDST_W:          be = 4'b1111;
            default:         be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lsu_store_data(input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            LDST_B, LDST_BU: d = {4{wdata[7:0]}};
            LDST_H, LDST_HU: d = {2{wdata[15:0]}};
            default:         d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/miriscv_lsu_load_align.sv
// Picks the addressed byte/half lane out of a memory word and sign- or zero-extends it.
module miriscv_lsu_load_align
    import miriscv_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_size,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension
    always_comb begin
        w_byte = i_rdata[{i_offset, 3'b000} +: 8];
        if (i_offset[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
        case (i_size)
            LDST_B:  o_data = {{24{w_byte[7]}}, w_byte};
            LDST_BU: o_data = {24'h000000, w_byte};
            LDST_H:  o_data = {{16{w_half[15]}}, w_half};
            LDST_HU: o_data = {16'h0000, w_half};
            LDST_W:  o_data = i_rdata;
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: one data-memory transaction per load/store over a req/ack handshake,
// stalling the core until the extended load data (or store completion) is reported.
module miriscv_lsu
    import miriscv_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_size,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_done,
    output logic              lsu_stall,
    output logic              lsu_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_lsu_rdata;
    logic [2:0]        r_size;
    logic [1:0]        r_off;
    logic              w_fault;
    logic              w_start;
    logic              w_ack;
    logic [DATA_W-1:0] w_load_data;

    assign w_fault = lsu_is_fault(lsu_size, lsu_addr[1:0]);
    assign w_start = (r_state == LSU_IDLE) && lsu_req && !w_fault;
    assign w_ack   = (r_state == LSU_BUSY) && mem_ack;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a request seen in DONE still belongs to the finished instruction
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LSU_IDLE: begin
                if (w_start) begin
                    w_state_nxt = LSU_BUSY;
                end else begin
                    w_state_nxt = LSU_IDLE;
                end
            end
            LSU_BUSY: begin
                if (mem_ack) begin
                    w_state_nxt = LSU_DONE;
                end else begin
                    w_state_nxt = LSU_BUSY;
                end
            end
            LSU_DONE: w_state_nxt = LSU_IDLE;
            default:  w_state_nxt = LSU_IDLE;
        endcase
    end

    // Memory-side request registers, held stable from issue until ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_size      <= 3'd0;
            r_off       <= 2'd0;
        end else if (w_start) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= lsu_we;
            r_mem_be    <= lsu_byte_en(lsu_size, lsu_addr[1:0]);
            r_mem_addr  <= {lsu_addr[ADDR_W-1:2], 2'b00};
            r_mem_wdata <= lsu_store_data(lsu_size, lsu_wdata);
            r_size      <= lsu_size;
            r_off       <= lsu_addr[1:0];
        end else if (w_ack) begin
            r_mem_req   <= 1'b0;
        end else begin
            r_mem_req   <= r_mem_req;
        end
    end

    // Load result capture; stores leave the previous value in place
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lsu_rdata <= '0;
        end else if (w_ack && !r_mem_we) begin
            r_lsu_rdata <= w_load_data;
        end else begin
            r_lsu_rdata <= r_lsu_rdata;
        end
    end

    miriscv_lsu_load_align u_load_align (
        .i_rdata  (mem_rdata),
        .i_offset (r_off),
        .i_size   (r_size),
        .o_data   (w_load_data)
    );

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign lsu_rdata = r_lsu_rdata;
    assign lsu_done  = (r_state == LSU_DONE);
    assign lsu_stall = w_start || (r_state == LSU_BUSY);
    assign lsu_fault = (r_state == LSU_IDLE) && lsu_req && w_fault;

endmodule
